// File: rtl/wb_commit_rob_pkg.sv
// Shared types and constants for the writeback reorder buffer.
// Optional build macro: ROB_PERF_CNT_EN (performance counters, see wb_commit_rob.sv).
package wb_commit_rob_pkg;

  localparam int WIDTH     = 32;
  localparam int RS        = 5;
  localparam int ROB_DEPTH = 8;

  typedef logic [$clog2(ROB_DEPTH)-1:0] rob_ptr_t;

  typedef struct packed {
    logic             valid;
    logic             done;
    logic             we;
    logic [RS-1:0]    rd;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] data;
  } rob_entry_t;

  // One register-file write port as seen by the RF.
  typedef struct packed {
    logic             en;
    logic [RS-1:0]    rd;
    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] pc;
  } rf_port_t;

  // Present a retiring entry on an RF port.
  function automatic rf_port_t rf_drive(input rob_entry_t e, input logic en);
    rf_port_t p;
    p.en = en;
    p.rd = e.rd;
    p.wd = e.data;
    p.pc = e.pc;
    return p;
  endfunction

endpackage

// File: rtl/wb_commit_rob_if.sv
// Bundle of dispatch, completion, flush and RF-write signals around the ROB.
// slave = the ROB itself, master = the surrounding pipeline / RF.
// Optional build macro: ROB_PERF_CNT_EN adds the performance counter outputs.
interface wb_commit_rob_if
  import wb_commit_rob_pkg::*;
#(
  parameter int DEPTH = ROB_DEPTH
);
  localparam int TAG_W = $clog2(DEPTH);

  logic [1:0]                  alloc_valid;
  logic [1:0][RS-1:0]          alloc_rd;
  logic [1:0]                  alloc_we;
  logic [1:0][WIDTH-1:0]       alloc_pc;
  logic                        alloc_ready;
  logic [1:0][TAG_W-1:0]       alloc_tag;

  logic                        cmpl_valid_Branch;
  logic [TAG_W-1:0]            cmpl_tag_Branch;
  logic [WIDTH-1:0]            cmpl_data_Branch;
  logic                        cmpl_valid_Memory;
  logic [TAG_W-1:0]            cmpl_tag_Memory;
  logic [WIDTH-1:0]            cmpl_data_Memory;

  logic                        flush_valid;
  logic [TAG_W-1:0]            flush_tag;

  logic [RS-1:0]               rd_Memory;
  logic [RS-1:0]               rd_Branch;
  logic [WIDTH-1:0]            wd_Memory;
  logic [WIDTH-1:0]            wd_Branch;
  logic [WIDTH-1:0]            PC_out_Memory;
  logic [WIDTH-1:0]            PC_out_Branch;
  logic                        write_en_Memory;
  logic                        write_en_Branch;
  logic                        empty;
`ifdef ROB_PERF_CNT_EN
  logic [31:0]                 perf_commit_cnt;
  logic [31:0]                 perf_stall_cnt;
`endif

  modport slave (
    input  alloc_valid, alloc_rd, alloc_we, alloc_pc,
    input  cmpl_valid_Branch, cmpl_tag_Branch, cmpl_data_Branch,
    input  cmpl_valid_Memory, cmpl_tag_Memory, cmpl_data_Memory,
    input  flush_valid, flush_tag,
    output alloc_ready, alloc_tag,
    output rd_Memory, rd_Branch, wd_Memory, wd_Branch,
    output PC_out_Memory, PC_out_Branch, write_en_Memory, write_en_Branch,
`ifdef ROB_PERF_CNT_EN
    output perf_commit_cnt, perf_stall_cnt,
`endif
    output empty
  );

  modport master (
    output alloc_valid, alloc_rd, alloc_we, alloc_pc,
    output cmpl_valid_Branch, cmpl_tag_Branch, cmpl_data_Branch,
    output cmpl_valid_Memory, cmpl_tag_Memory, cmpl_data_Memory,
    output flush_valid, flush_tag,
    input  alloc_ready, alloc_tag,
    input  rd_Memory, rd_Branch, wd_Memory, wd_Branch,
    input  PC_out_Memory, PC_out_Branch, write_en_Memory, write_en_Branch,
`ifdef ROB_PERF_CNT_EN
    input  perf_commit_cnt, perf_stall_cnt,
`endif
    input  empty
  );

endinterface

// File: rtl/wb_commit_rob_commit_select.sv
// Commit selection for the two oldest ROB entries: retire readiness,
// RF write qualification, same-rd suppression and port mapping
// (older slot -> Memory port, younger slot -> Branch port).
module wb_commit_select
  import wb_commit_rob_pkg::*;
(
  input  rob_entry_t i_ent0,
  input  rob_entry_t i_ent1,
  output logic       o_c0,
  output logic       o_c1,
  output rf_port_t   o_port_m,
  output rf_port_t   o_port_b
);

  logic w_we0;
  logic w_we1;
  logic w_same_rd;

  // Retire in order; when both slots write the same rd only the younger result reaches the RF.
  always_comb begin
    o_c0      = i_ent0.valid && i_ent0.done;
    o_c1      = o_c0 && i_ent1.valid && i_ent1.done;
    w_we0     = o_c0 && i_ent0.we && (i_ent0.rd != '0);
    w_we1     = o_c1 && i_ent1.we && (i_ent1.rd != '0);
    w_same_rd = w_we0 && w_we1 && (i_ent0.rd == i_ent1.rd);
    o_port_m  = '0;
    o_port_b  = '0;
    if (o_c0 && !w_same_rd) o_port_m = rf_drive(i_ent0, w_we0);
    if (o_c1)               o_port_b = rf_drive(i_ent1, w_we1);
  end

endmodule

// File: rtl/wb_commit_rob.sv
// Dual-issue writeback reorder buffer. Holds entry storage, head/tail/count
// pointers and the registered RF write ports; commit selection lives in
// wb_commit_select.
// Optional build macro: ROB_PERF_CNT_EN adds perf_commit_cnt / perf_stall_cnt.
module wb_commit_rob
  import wb_commit_rob_pkg::*;
#(
  parameter int DEPTH = ROB_DEPTH
)
(
  input  logic            clk,
  input  logic            rst,
  wb_commit_rob_if.slave  bus
);

  localparam int TAG_W = $clog2(DEPTH);
  localparam int CNT_W = TAG_W + 1;

  rob_entry_t       r_ent [DEPTH];
  logic [TAG_W-1:0] r_head;
  logic [TAG_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  rf_port_t         r_port_m;
  rf_port_t         r_port_b;

  logic [TAG_W-1:0] w_head1;
  logic [TAG_W-1:0] w_tail1;
  logic [TAG_W-1:0] w_flush_off;
  logic [TAG_W-1:0] w_tail_next;
  logic [CNT_W-1:0] w_count_next;
  logic [CNT_W-1:0] w_ncommit;
  logic [CNT_W-1:0] w_nalloc;
  logic             w_flush;
  logic             w_alloc_ready;
  logic             w_alloc0;
  logic             w_alloc1;
  logic [DEPTH-1:0] w_kill;
  rob_entry_t       w_ent0;
  rob_entry_t       w_ent1;
  logic             w_c0;
  logic             w_c1;
  rf_port_t         w_port_m;
  rf_port_t         w_port_b;

  assign w_head1       = r_head + TAG_W'(1);
  assign w_tail1       = r_tail + TAG_W'(1);
  assign w_flush_off   = bus.flush_tag - r_head;
  // A flush naming a tag that is not live is ignored entirely.
  assign w_flush       = bus.flush_valid && r_ent[bus.flush_tag].valid;
  assign w_alloc_ready = (r_count <= CNT_W'(DEPTH - 2));
  assign w_alloc0      = bus.alloc_valid[0] && w_alloc_ready && !w_flush;
  assign w_alloc1      = w_alloc0 && bus.alloc_valid[1];
  assign w_nalloc      = CNT_W'(w_alloc0) + CNT_W'(w_alloc1);
  assign w_ncommit     = CNT_W'(w_c0) + CNT_W'(w_c1);

  // Oldest two entries; when the flush keeps only the head, head+1 is being squashed and must not retire.
  always_comb begin
    w_ent0 = r_ent[r_head];
    w_ent1 = r_ent[w_head1];
    if (w_flush && (w_flush_off == '0)) w_ent1.valid = 1'b0;
  end

  wb_commit_select u_select (
    .i_ent0   (w_ent0),
    .i_ent1   (w_ent1),
    .o_c0     (w_c0),
    .o_c1     (w_c1),
    .o_port_m (w_port_m),
    .o_port_b (w_port_b)
  );

  // Entries whose age (distance from head) exceeds the flush tag's age are squashed.
  always_comb begin
    w_kill = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_kill[i] = w_flush && ((TAG_W'(i) - r_head) > w_flush_off);
    end
  end

  // Next tail and occupancy; after a flush the survivors are head..flush_tag minus this cycle's commits.
  always_comb begin
    w_tail_next  = r_tail + w_nalloc[TAG_W-1:0];
    w_count_next = r_count + w_nalloc - w_ncommit;
    if (w_flush) begin
      w_tail_next  = bus.flush_tag + TAG_W'(1);
      w_count_next = CNT_W'(w_flush_off) + CNT_W'(1) - w_ncommit;
    end
  end

  // Entry storage: completion, then retire, squash and allocation (later writes take precedence).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) r_ent[i] <= '0;
    end else begin
      if (bus.cmpl_valid_Branch && r_ent[bus.cmpl_tag_Branch].valid) begin
        r_ent[bus.cmpl_tag_Branch].done <= 1'b1;
        r_ent[bus.cmpl_tag_Branch].data <= bus.cmpl_data_Branch;
      end
      if (bus.cmpl_valid_Memory && r_ent[bus.cmpl_tag_Memory].valid) begin
        r_ent[bus.cmpl_tag_Memory].done <= 1'b1;
        r_ent[bus.cmpl_tag_Memory].data <= bus.cmpl_data_Memory;
      end
      if (w_c0) begin
        r_ent[r_head].valid <= 1'b0;
        r_ent[r_head].done  <= 1'b0;
      end
      if (w_c1) begin
        r_ent[w_head1].valid <= 1'b0;
        r_ent[w_head1].done  <= 1'b0;
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (w_kill[i]) begin
          r_ent[i].valid <= 1'b0;
          r_ent[i].done  <= 1'b0;
        end
      end
      if (w_alloc0) begin
        r_ent[r_tail] <= '{valid: 1'b1, done: 1'b0, we: bus.alloc_we[0],
                           rd: bus.alloc_rd[0], pc: bus.alloc_pc[0], data: '0};
      end
      if (w_alloc1) begin
        r_ent[w_tail1] <= '{valid: 1'b1, done: 1'b0, we: bus.alloc_we[1],
                            rd: bus.alloc_rd[1], pc: bus.alloc_pc[1], data: '0};
      end
    end
  end

  // Ring pointers and occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + w_ncommit[TAG_W-1:0];
      r_tail  <= w_tail_next;
      r_count <= w_count_next;
    end
  end

  // Registered RF write ports.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_port_m <= '0;
      r_port_b <= '0;
    end else begin
      r_port_m <= w_port_m;
      r_port_b <= w_port_b;
    end
  end

  assign bus.alloc_ready     = w_alloc_ready;
  assign bus.alloc_tag[0]    = r_tail;
  assign bus.alloc_tag[1]    = w_tail1;
  assign bus.empty           = (r_count == '0);
  assign bus.write_en_Memory = r_port_m.en;
  assign bus.rd_Memory       = r_port_m.rd;
  assign bus.wd_Memory       = r_port_m.wd;
  assign bus.PC_out_Memory   = r_port_m.pc;
  assign bus.write_en_Branch = r_port_b.en;
  assign bus.rd_Branch       = r_port_b.rd;
  assign bus.wd_Branch       = r_port_b.wd;
  assign bus.PC_out_Branch   = r_port_b.pc;

`ifdef ROB_PERF_CNT_EN
  logic [31:0] r_perf_commit;
  logic [31:0] r_perf_stall;

  // Retired-entry total and cycles where dispatch was held off by a full buffer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_perf_commit <= '0;
      r_perf_stall  <= '0;
    end else begin
      r_perf_commit <= r_perf_commit + 32'(w_ncommit);
      r_perf_stall  <= r_perf_stall + 32'(bus.alloc_valid[0] && !w_alloc_ready);
    end
  end

  assign bus.perf_commit_cnt = r_perf_commit;
  assign bus.perf_stall_cnt  = r_perf_stall;
`endif

endmodule

// File: tb/tb_wb_commit_rob.sv
// Directed bench for wb_commit_rob: a per-cycle vector table for the basic
// flows, followed by hand-written fill/wrap, flush and async-reset sequences.
module tb_wb_commit_rob;
  import wb_commit_rob_pkg::*;

  typedef struct packed {
    logic        en;
    logic [4:0]  rd;
    logic [31:0] wd;
    logic [31:0] pc;
  } port_t;

  typedef struct {
    logic [1:0]  av;
    logic [4:0]  rd0, rd1;
    logic [31:0] pc0, pc1;
    logic        bv;
    logic [2:0]  bt;
    logic [31:0] bd;
    logic        mv;
    logic [2:0]  mt;
    logic [31:0] md;
    port_t       em, eb;
    logic        emp, rdy;
    logic [2:0]  tag0;
  } vec_t;

  localparam port_t IDLE = '0;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs [16];

  wb_commit_rob_if bus ();

  wb_commit_rob dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  function automatic port_t P(input int en, input int rd, input int wd, input int pc);
    port_t p;
    p.en = 1'(en);
    p.rd = 5'(rd);
    p.wd = 32'(wd);
    p.pc = 32'(pc);
    return p;
  endfunction

  function automatic vec_t mk(input int av, input int rd0, input int pc0, input int rd1, input int pc1,
                              input int bv, input int bt, input int bd,
                              input int mv, input int mt, input int md,
                              input port_t em, input port_t eb,
                              input int emp, input int rdy, input int tag0);
    vec_t v;
    v.av = 2'(av);  v.rd0 = 5'(rd0); v.pc0 = 32'(pc0); v.rd1 = 5'(rd1); v.pc1 = 32'(pc1);
    v.bv = 1'(bv);  v.bt = 3'(bt);   v.bd = 32'(bd);
    v.mv = 1'(mv);  v.mt = 3'(mt);   v.md = 32'(md);
    v.em = em;      v.eb = eb;
    v.emp = 1'(emp); v.rdy = 1'(rdy); v.tag0 = 3'(tag0);
    return v;
  endfunction

  function automatic port_t act_m();
    return {bus.write_en_Memory, bus.rd_Memory, bus.wd_Memory, bus.PC_out_Memory};
  endfunction

  function automatic port_t act_b();
    return {bus.write_en_Branch, bus.rd_Branch, bus.wd_Branch, bus.PC_out_Branch};
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic chk_ports(input string nm, input port_t em, input port_t eb);
    chk({nm, "_mem"}, 128'(act_m()), 128'(em));
    chk({nm, "_br"},  128'(act_b()), 128'(eb));
  endtask

  task automatic alloc_in(input int av, input int rd0, input int pc0, input int rd1, input int pc1);
    bus.alloc_valid = 2'(av);
    bus.alloc_rd[0] = 5'(rd0);
    bus.alloc_pc[0] = 32'(pc0);
    bus.alloc_rd[1] = 5'(rd1);
    bus.alloc_pc[1] = 32'(pc1);
    bus.alloc_we    = 2'b11;
  endtask

  task automatic cmpl_in(input int bv, input int bt, input int bd, input int mv, input int mt, input int md);
    bus.cmpl_valid_Branch = 1'(bv);
    bus.cmpl_tag_Branch   = 3'(bt);
    bus.cmpl_data_Branch  = 32'(bd);
    bus.cmpl_valid_Memory = 1'(mv);
    bus.cmpl_tag_Memory   = 3'(mt);
    bus.cmpl_data_Memory  = 32'(md);
  endtask

  task automatic idle_in();
    alloc_in(0, 0, 0, 0, 0);
    cmpl_in(0, 0, 0, 0, 0, 0);
    bus.flush_valid = 1'b0;
    bus.flush_tag   = '0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_in();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int    nwr;
    port_t last;

    // tags and tail after each row follow from one-reset-then-continuous operation
    vecs[0]  = mk(1, 5, 'h100, 0, 0,        0, 0, 0,      0, 0, 0,      IDLE, IDLE, 0, 1, 1);
    vecs[1]  = mk(0, 0, 0, 0, 0,            1, 0, 'hAA,   0, 0, 0,      IDLE, IDLE, 0, 1, 1);
    vecs[2]  = mk(0, 0, 0, 0, 0,            0, 0, 0,      0, 0, 0,      P(1, 5, 'hAA, 'h100), IDLE, 1, 1, 1);
    vecs[3]  = mk(0, 0, 0, 0, 0,            0, 0, 0,      0, 0, 0,      IDLE, IDLE, 1, 1, 1);
    vecs[4]  = mk(3, 3, 'h200, 4, 'h204,    0, 0, 0,      0, 0, 0,      IDLE, IDLE, 0, 1, 3);
    vecs[5]  = mk(0, 0, 0, 0, 0,            1, 2, 'h44,   0, 0, 0,      IDLE, IDLE, 0, 1, 3);
    vecs[6]  = mk(0, 0, 0, 0, 0,            0, 0, 0,      1, 1, 'h33,   IDLE, IDLE, 0, 1, 3);
    vecs[7]  = mk(0, 0, 0, 0, 0,            0, 0, 0,      0, 0, 0,      P(1, 3, 'h33, 'h200), P(1, 4, 'h44, 'h204), 1, 1, 3);
    vecs[8]  = mk(0, 0, 0, 0, 0,            0, 0, 0,      0, 0, 0,      IDLE, IDLE, 1, 1, 3);
    vecs[9]  = mk(3, 7, 'h300, 7, 'h304,    0, 0, 0,      0, 0, 0,      IDLE, IDLE, 0, 1, 5);
    vecs[10] = mk(0, 0, 0, 0, 0,            1, 4, 'h71,   1, 3, 'h70,   IDLE, IDLE, 0, 1, 5);
    vecs[11] = mk(0, 0, 0, 0, 0,            0, 0, 0,      0, 0, 0,      IDLE, P(1, 7, 'h71, 'h304), 1, 1, 5);
    vecs[12] = mk(0, 0, 0, 0, 0,            0, 0, 0,      0, 0, 0,      IDLE, IDLE, 1, 1, 5);
    vecs[13] = mk(1, 9, 'h400, 0, 0,        0, 0, 0,      0, 0, 0,      IDLE, IDLE, 0, 1, 6);
    vecs[14] = mk(0, 0, 0, 0, 0,            1, 5, 'hBB,   1, 5, 'hCC,   IDLE, IDLE, 0, 1, 6);
    vecs[15] = mk(0, 0, 0, 0, 0,            0, 0, 0,      0, 0, 0,      P(1, 9, 'hCC, 'h400), IDLE, 1, 1, 6);

    rst = 1'b0;
    idle_in();
    #12;
    chk_ports("reset", IDLE, IDLE);
    chk("reset_status", 128'({bus.empty, bus.alloc_ready, bus.alloc_tag[0], bus.alloc_tag[1]}), 128'({1'b1, 1'b1, 3'd0, 3'd1}));
    @(negedge clk);
    rst = 1'b1;

    // table: single commit latency, out-of-order pair, same-rd, Memory-wins
    for (int i = 0; i < 16; i++) begin
      alloc_in(vecs[i].av, vecs[i].rd0, vecs[i].pc0, vecs[i].rd1, vecs[i].pc1);
      cmpl_in(vecs[i].bv, vecs[i].bt, vecs[i].bd, vecs[i].mv, vecs[i].mt, vecs[i].md);
      cyc();
      chk_ports($sformatf("vec%0d", i), vecs[i].em, vecs[i].eb);
      chk($sformatf("vec%0d_status", i), 128'({bus.empty, bus.alloc_ready, bus.alloc_tag[0]}),
          128'({vecs[i].emp, vecs[i].rdy, vecs[i].tag0}));
    end
    idle_in();

    // fill to 7 entries, held allocation, wrap of tags 7 -> 0
    do_reset();
    for (int k = 0; k < 3; k++) begin
      alloc_in(3, 2 * k + 1, 'h1000 + 8 * k, 2 * k + 2, 'h1004 + 8 * k);
      cyc();
    end
    chk("fill6", 128'({bus.alloc_ready, bus.alloc_tag[0]}), 128'({1'b1, 3'd6}));
    alloc_in(1, 7, 'h1018, 0, 0);
    cyc();
    chk("fill7", 128'({bus.alloc_ready, bus.alloc_tag[0]}), 128'({1'b0, 3'd7}));
    alloc_in(1, 9, 'h2000, 0, 0);
    cyc();
    chk("held_ignored", 128'({bus.alloc_ready, bus.alloc_tag[0]}), 128'({1'b0, 3'd7}));
    cmpl_in(1, 0, 1, 0, 0, 0);
    cyc();
    cmpl_in(0, 0, 0, 0, 0, 0);
    cyc();
    chk_ports("fill_commit0", P(1, 1, 1, 'h1000), IDLE);
    chk("space_freed", 128'({bus.alloc_ready, bus.alloc_tag[0]}), 128'({1'b1, 3'd7}));
    cyc();
    chk("held_accepted_wrap", 128'({bus.alloc_ready, bus.alloc_tag[0]}), 128'({1'b0, 3'd0}));
    idle_in();
    nwr  = 0;
    last = IDLE;
    for (int t = 1; t <= 7; t++) begin
      cmpl_in(0, 0, 0, 1, t, 'h100 + t);
      cyc();
      if (bus.write_en_Memory) begin nwr++; last = act_m(); end
      if (bus.write_en_Branch) begin nwr++; last = act_b(); end
    end
    cmpl_in(0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      cyc();
      if (bus.write_en_Memory) begin nwr++; last = act_m(); end
      if (bus.write_en_Branch) begin nwr++; last = act_b(); end
    end
    chk("drain_writes", 128'(nwr), 128'(7));
    chk("drain_last", 128'(last), 128'(P(1, 9, 'h107, 'h2000)));
    chk("drain_empty", 128'(bus.empty), 128'(1'b1));
`ifdef ROB_PERF_CNT_EN
    chk("perf_commit", 128'(bus.perf_commit_cnt), 128'(8));
    chk("perf_stall", 128'(bus.perf_stall_cnt), 128'(3));
`endif

    // flush keeps tags 0..2, blocks the concurrent alloc, drops a late completion
    do_reset();
    for (int k = 0; k < 3; k++) begin
      alloc_in(3, 10 + 2 * k, 'h500 + 8 * k, 11 + 2 * k, 'h504 + 8 * k);
      cyc();
    end
    alloc_in(1, 30, 'h999, 0, 0);
    bus.flush_valid = 1'b1;
    bus.flush_tag   = 3'd2;
    cyc();
    idle_in();
    chk("flush_tail", 128'({bus.empty, bus.alloc_tag[0]}), 128'({1'b0, 3'd3}));
    cmpl_in(1, 4, 'hDEAD, 0, 0, 0);
    cyc();
    cmpl_in(1, 1, 'h11, 1, 0, 'h10);
    cyc();
    chk_ports("flush_wait", IDLE, IDLE);
    cmpl_in(1, 2, 'h12, 0, 0, 0);
    cyc();
    chk_ports("flush_pair", P(1, 10, 'h10, 'h500), P(1, 11, 'h11, 'h504));
    cmpl_in(0, 0, 0, 0, 0, 0);
    cyc();
    chk_ports("flush_tag2", P(1, 12, 'h12, 'h508), IDLE);
    chk("flush_empty", 128'(bus.empty), 128'(1'b1));
    alloc_in(1, 20, 'h600, 0, 0);
    cyc();
    idle_in();
    chk("flush_realloc", 128'(bus.alloc_tag[0]), 128'(3'd4));
    cmpl_in(0, 0, 0, 1, 3, 'h20);
    cyc();
    cmpl_in(0, 0, 0, 0, 0, 0);
    cyc();
    chk_ports("flush_no_ghost", P(1, 20, 'h20, 'h600), IDLE);

    // asynchronous reset while writes are in flight
    do_reset();
    alloc_in(3, 1, 'h700, 2, 'h704);
    cyc();
    alloc_in(1, 3, 'h708, 0, 0);
    cmpl_in(1, 1, 2, 1, 0, 1);
    cyc();
    idle_in();
    cmpl_in(1, 2, 3, 0, 0, 0);
    cyc();
    chk("pre_reset_write", 128'({bus.write_en_Memory, bus.write_en_Branch}), 128'(2'b11));
    #2;
    rst = 1'b0;
    #1;
    chk_ports("async_reset", IDLE, IDLE);
    chk("async_reset_status", 128'({bus.empty, bus.alloc_ready, bus.alloc_tag[0]}), 128'({1'b1, 1'b1, 3'd0}));
    idle_in();
    @(negedge clk);
    rst = 1'b1;
    nwr = 0;
    for (int k = 0; k < 6; k++) begin
      cyc();
      if (bus.write_en_Memory || bus.write_en_Branch) nwr++;
    end
    chk("post_reset_quiet", 128'(nwr), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
